// File: rtl/i2s_transmitter_pkg.sv
// Shared audio definitions: sample width, I2S word-select encoding and transmitter states.
package i2s_transmitter_pkg;

    localparam int unsigned SAMPLE_WIDTH  = 16;
    localparam int unsigned I2S_SLOT_BITS = 16;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

    typedef enum logic {
        IDLE,
        RUN
    } tx_state_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S clock generation: bclk divider, falling-edge strobe, bit counter and lrclk.
module i2s_clk_gen
    import i2s_transmitter_pkg::*;
#(
    parameter int unsigned SLOT_BITS = I2S_SLOT_BITS,
    parameter int unsigned CLK_DIV   = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic bclk,
    output logic lrclk,
    output logic fall_c,
    output logic frame_c
);

    localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
    localparam int unsigned DIV_W      = $clog2(CLK_DIV);
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_nxt_c;
    logic             div_tc_c;
    logic             bit_last_c;

    assign div_tc_c   = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign bit_last_c = (bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign bit_nxt_c  = bit_last_c ? '0 : bit_cnt + BIT_W'(1);
    assign fall_c     = div_tc_c & bclk;
    assign frame_c    = fall_c & bit_last_c;

    // Bit counter parks on the last bit so the first fall event opens a frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            bit_cnt <= BIT_W'(FRAME_BITS - 1);
            lrclk   <= LR_RIGHT;
        end else begin
            div_cnt <= div_tc_c ? '0 : div_cnt + DIV_W'(1);
            if (div_tc_c) begin
                bclk <= ~bclk;
            end
            if (fall_c) begin
                bit_cnt <= bit_nxt_c;
                lrclk   <= (bit_nxt_c < BIT_W'(SLOT_BITS)) ? LR_LEFT : LR_RIGHT;
            end
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// Double-buffered stereo I2S transmitter with valid/ready sample input.
// Optional saturating underrun counter enabled by I2S_TX_UNDERRUN_CNT_EN.
module i2s_transmitter
    import i2s_transmitter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SAMPLE_WIDTH,
    parameter int unsigned SLOT_BITS  = I2S_SLOT_BITS,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    input  logic [DATA_WIDTH-1:0] audio_left_in,
    input  logic [DATA_WIDTH-1:0] audio_right_in,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata,
    output logic                  underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]           underrun_count
`endif
);

    localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
    localparam int unsigned PAD_BITS   = SLOT_BITS - DATA_WIDTH;

    tx_state_t             state;
    tx_state_t             state_nxt;
    logic                  fall_c;
    logic                  frame_c;
    logic                  accept_c;
    logic                  underrun_c;
    logic                  ready_nxt_c;
    logic [FRAME_BITS-1:0] shift_q;
    logic [FRAME_BITS-1:0] shift_nxt_c;
    logic [DATA_WIDTH-1:0] hold_left;
    logic [DATA_WIDTH-1:0] hold_right;

    // Each sample is left-justified in its slot, zero padded below.
    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [DATA_WIDTH-1:0] l,
                                                         input logic [DATA_WIDTH-1:0] r);
        logic [SLOT_BITS-1:0] ls;
        logic [SLOT_BITS-1:0] rs;
        ls = SLOT_BITS'(l) << PAD_BITS;
        rs = SLOT_BITS'(r) << PAD_BITS;
        return {ls, rs};
    endfunction

    i2s_clk_gen #(
        .SLOT_BITS (SLOT_BITS),
        .CLK_DIV   (CLK_DIV)
    ) u_clk_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .bclk    (bclk),
        .lrclk   (lrclk),
        .fall_c  (fall_c),
        .frame_c (frame_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A pair arriving on an empty-holding frame boundary bypasses straight into the shifter.
    always_comb begin
        state_nxt   = state;
        accept_c    = sample_valid & sample_ready;
        underrun_c  = 1'b0;
        ready_nxt_c = sample_ready;
        shift_nxt_c = shift_q;
        case (state)
            IDLE:    if (accept_c) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
        if (frame_c) begin
            ready_nxt_c = 1'b1;
            if (!sample_ready) begin
                shift_nxt_c = frame_word(hold_left, hold_right);
            end else if (accept_c) begin
                shift_nxt_c = frame_word(audio_left_in, audio_right_in);
            end else begin
                shift_nxt_c = '0;
                underrun_c  = (state == RUN);
            end
        end else begin
            if (accept_c) begin
                ready_nxt_c = 1'b0;
            end
            if (fall_c) begin
                shift_nxt_c = {shift_q[FRAME_BITS-2:0], 1'b0};
            end
        end
    end

    // sdata takes the shifter MSB one bclk late, giving the I2S one-bit delay.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_left    <= '0;
            hold_right   <= '0;
            shift_q      <= '0;
            sample_ready <= 1'b1;
            underrun     <= 1'b0;
            sdata        <= 1'b0;
        end else begin
            if (accept_c && !frame_c) begin
                hold_left  <= audio_left_in;
                hold_right <= audio_right_in;
            end
            if (fall_c) begin
                sdata <= shift_q[FRAME_BITS-1];
            end
            shift_q      <= shift_nxt_c;
            sample_ready <= ready_nxt_c;
            underrun     <= underrun_c;
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_count <= '0;
        end else if (underrun_c && (underrun_count != 16'hFFFF)) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: two instances (16- and 24-bit slots) against a frame-level reference model.
module tb_i2s_transmitter;

    localparam int CD = 2;
    localparam int S0 = 16;
    localparam int S1 = 24;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid [2];
    logic [15:0] lin   [2];
    logic [15:0] rin   [2];
    logic        bclk_w[2];
    logic        lr_w  [2];
    logic        sd_w  [2];
    logic        rdy_w [2];
    logic        ur_w  [2];
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] cnt_w [2];
`endif

    always #5 clk = ~clk;

    i2s_transmitter #(.DATA_WIDTH(16), .SLOT_BITS(S0), .CLK_DIV(CD)) dut0 (
        .clk            (clk),
        .reset_n        (reset_n),
        .sample_valid   (valid[0]),
        .sample_ready   (rdy_w[0]),
        .audio_left_in  (lin[0]),
        .audio_right_in (rin[0]),
        .bclk           (bclk_w[0]),
        .lrclk          (lr_w[0]),
        .sdata          (sd_w[0]),
        .underrun       (ur_w[0])
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_count (cnt_w[0])
`endif
    );

    i2s_transmitter #(.DATA_WIDTH(16), .SLOT_BITS(S1), .CLK_DIV(CD)) dut1 (
        .clk            (clk),
        .reset_n        (reset_n),
        .sample_valid   (valid[1]),
        .sample_ready   (rdy_w[1]),
        .audio_left_in  (lin[1]),
        .audio_right_in (rin[1]),
        .bclk           (bclk_w[1]),
        .lrclk          (lr_w[1]),
        .sdata          (sd_w[1]),
        .underrun       (ur_w[1])
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_count (cnt_w[1])
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          n, k;
    logic        e_bclk;
    logic        m_full [2];
    logic [31:0] m_pair [2];
    logic        m_run  [2];
    logic        m_acc  [2];
    int          m_b    [2];
    logic [47:0] cur    [2];
    logic [47:0] prev   [2];
    logic        e_lr   [2];
    logic        e_sd   [2];
    logic        e_ur   [2];
    logic [15:0] m_cnt  [2];
    logic [47:0] rx     [2];
    logic [47:0] last_rx[2];
    int          frames_done[2];
    int          pulses [2];

    function automatic int sbits(int i);
        return (i == 0) ? S0 : S1;
    endfunction

    // Frame as sent MSB-first: left in the top slot, right below, each left-justified.
    function automatic logic [47:0] fw(int s, logic [31:0] p);
        logic [47:0] l;
        logic [47:0] r;
        l = 48'(p[31:16]);
        r = 48'(p[15:0]);
        return (l << (2 * s - 16)) | (r << (s - 16));
    endfunction

    task automatic chk(string tag, logic [47:0] obs, logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n = 0;
        k = 0;
        e_bclk = 1'b0;
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0;
            m_full[i] = 1'b0;
            m_pair[i] = '0;
            m_run[i] = 1'b0;
            m_acc[i] = 1'b0;
            m_b[i] = 0;
            cur[i] = '0;
            prev[i] = '0;
            e_lr[i] = 1'b1;
            e_sd[i] = 1'b0;
            e_ur[i] = 1'b0;
            m_cnt[i] = '0;
            rx[i] = '0;
            last_rx[i] = '0;
            frames_done[i] = 0;
            pulses[i] = 0;
        end
    endtask

    task automatic chk_reset(string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_bclk%0d", tag, i), 48'(bclk_w[i]), 48'(0));
            chk($sformatf("%s_lrclk%0d", tag, i), 48'(lr_w[i]), 48'(1));
            chk($sformatf("%s_sdata%0d", tag, i), 48'(sd_w[i]), 48'(0));
            chk($sformatf("%s_ready%0d", tag, i), 48'(rdy_w[i]), 48'(1));
            chk($sformatf("%s_underrun%0d", tag, i), 48'(ur_w[i]), 48'(0));
`ifdef I2S_TX_UNDERRUN_CNT_EN
            chk($sformatf("%s_count%0d", tag, i), 48'(cnt_w[i]), 48'(0));
`endif
        end
    endtask

    // One clk: advance the timing/frame model, then compare every output and decode sdata.
    task automatic step();
        logic fall;
        for (int i = 0; i < 2; i++) m_acc[i] = valid[i] && !m_full[i];
        @(posedge clk);
        n++;
        fall = (n % (2 * CD) == 0);
        if (fall) k++;
        e_bclk = ((n / CD) % 2) == 1;
        for (int i = 0; i < 2; i++) begin
            int s;
            s = sbits(i);
            e_ur[i] = 1'b0;
            if (m_acc[i]) begin
                m_full[i] = 1'b1;
                m_pair[i] = {lin[i], rin[i]};
                m_run[i] = 1'b1;
            end
            if (fall) begin
                m_b[i] = (k - 1) % (2 * s);
                if (m_b[i] == 0) begin
                    prev[i] = cur[i];
                    if (m_full[i]) begin
                        cur[i] = fw(s, m_pair[i]);
                        m_full[i] = 1'b0;
                    end else begin
                        cur[i] = '0;
                        if (m_run[i]) begin
                            e_ur[i] = 1'b1;
                            if (m_cnt[i] != 16'hFFFF) m_cnt[i] = m_cnt[i] + 16'd1;
                        end
                    end
                end
                e_lr[i] = (m_b[i] >= s);
                e_sd[i] = (m_b[i] == 0) ? prev[i][0] : cur[i][2 * s - m_b[i]];
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            int s;
            s = sbits(i);
            chk($sformatf("bclk%0d@%0d", i, n), 48'(bclk_w[i]), 48'(e_bclk));
            chk($sformatf("lrclk%0d@%0d", i, n), 48'(lr_w[i]), 48'(e_lr[i]));
            chk($sformatf("sdata%0d@%0d", i, n), 48'(sd_w[i]), 48'(e_sd[i]));
            chk($sformatf("ready%0d@%0d", i, n), 48'(rdy_w[i]), 48'(!m_full[i]));
            chk($sformatf("underrun%0d@%0d", i, n), 48'(ur_w[i]), 48'(e_ur[i]));
`ifdef I2S_TX_UNDERRUN_CNT_EN
            chk($sformatf("count%0d@%0d", i, n), 48'(cnt_w[i]), 48'(m_cnt[i]));
`endif
            if (ur_w[i] === 1'b1) pulses[i]++;
            if ((n % (2 * CD) == CD) && (k >= 1)) begin
                rx[i] = {rx[i][46:0], sd_w[i]};
                if ((m_b[i] == 0) && (k > 1)) begin
                    frames_done[i]++;
                    last_rx[i] = rx[i] & ((48'd1 << (2 * s)) - 48'd1);
                end
            end
        end
    endtask

    task automatic send(int i, logic [15:0] l, logic [15:0] r);
        bit got;
        got = 1'b0;
        valid[i] = 1'b1;
        lin[i] = l;
        rin[i] = r;
        for (int c = 0; c < 1000 && !got; c++) begin
            step();
            got = m_acc[i];
        end
        valid[i] = 1'b0;
    endtask

    task automatic wait_nonzero(int i, logic [47:0] exp, string tag);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 1200 && !got; c++) begin
            int fd;
            fd = frames_done[i];
            step();
            if ((frames_done[i] != fd) && (last_rx[i] != '0)) got = 1'b1;
        end
        chk(tag, last_rx[i], exp);
    endtask

    task automatic wait_next(int i, logic [47:0] exp, string tag);
        int fd;
        fd = frames_done[i];
        for (int c = 0; c < 1200 && frames_done[i] == fd; c++) step();
        chk(tag, (frames_done[i] == fd) ? 48'hDEAD : last_rx[i], exp);
    endtask

    initial begin
        int tgt;
        reset_n = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            lin[i] = '0;
            rin[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        reset_n = 1'b1;

        // Idle: clocks run, zeros sent, no underrun before the first pair.
        repeat (400) step();
        chk("idle_pulses0", 48'(pulses[0]), 48'(0));
        chk("idle_pulses1", 48'(pulses[1]), 48'(0));

        // Present a pair exactly on a frame boundary with holding empty.
        tgt = 2 * CD;
        while (tgt <= n + 1) tgt += 2 * CD * 2 * S0;
        while (n < tgt - 1) step();
        valid[0] = 1'b1;
        lin[0] = 16'hA5C3;
        rin[0] = 16'h1234;
        step();
        valid[0] = 1'b0;
        chk("bypass_ready", 48'(rdy_w[0]), 48'(1));
        chk("bypass_underrun", 48'(ur_w[0]), 48'(0));
        wait_nonzero(0, 48'h0000_A5C3_1234, "frame_a5c3_1234");

        send(1, 16'h8001, 16'h7FFE);
        wait_nonzero(1, 48'h800100_7FFE00, "frame24_8001_7ffe");

        // Second pair held on valid while not ready goes in the very next frame.
        send(0, 16'h1357, 16'h2468);
        send(0, 16'hFEDC, 16'h0BA9);
        wait_nonzero(0, 48'h0000_1357_2468, "frame_p1");
        pulses[0] = 0;
        wait_next(0, 48'h0000_FEDC_0BA9, "frame_p2");
        repeat (2 * 4 * S0 * CD) step();
        chk("starve_pulses", 48'(pulses[0]), 48'(3));

        // Random producers on both instances.
        for (int c = 0; c < 1500; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (valid[i] && m_acc[i]) valid[i] = 1'b0;
                if (!valid[i] && $urandom_range(0, 99) < 3) begin
                    valid[i] = 1'b1;
                    lin[i] = 16'($urandom);
                    rin[i] = 16'($urandom);
                end
            end
        end
        valid[0] = 1'b0;
        valid[1] = 1'b0;

        // Reset in the middle of the right slot.
        for (int c = 0; c < 400 && m_b[0] != S0 + 3; c++) step();
        chk("in_right_slot", 48'(lr_w[0]), 48'(1));
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset("midreset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();

        // Single pair then three starved frames after a fresh reset.
        send(0, 16'h0F0F, 16'hF0F0);
        wait_nonzero(0, 48'h0000_0F0F_F0F0, "frame_0f0f_f0f0");
        repeat (2 * 4 * S0 * CD) step();
        chk("post_reset_pulses0", 48'(pulses[0]), 48'(3));
        chk("post_reset_pulses1", 48'(pulses[1]), 48'(0));
`ifdef I2S_TX_UNDERRUN_CNT_EN
        chk("underrun_count0", 48'(cnt_w[0]), 48'(3));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

Serialises the stereo sample pair produced by the delay/echo path into an I2S bit stream for the codec DAC. It is the output-side counterpart of the sample-capture path: it accepts one left/right pair per frame through a valid/ready handshake, double-buffers it, and shifts it out MSB-first on a generated bit clock and word-select clock. It sits between the effect chain and the codec pins.

## Interface
- DATA_WIDTH, 16: sample width in bits, two's complement.
- SLOT_BITS, 16: bit clocks per channel slot; must be >= DATA_WIDTH.
- CLK_DIV, 4: clk cycles per bclk half-period; must be >= 2.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sample_valid  in  1  audio_left_in/audio_right_in hold a new pair.
- sample_ready  out  1  holding register empty; pair accepted when valid & ready.
- audio_left_in  in  DATA_WIDTH  left sample.
- audio_right_in  in  DATA_WIDTH  right sample.
- bclk  out  1  bit clock to codec.
- lrclk  out  1  word select: 0 = left slot, 1 = right slot.
- sdata  out  1  serial data, changes only on bclk falling edges.
- underrun  out  1  one-clk pulse when a frame starts with no pair held.
- underrun_count  out  16  saturating underrun count (only with I2S_TX_UNDERRUN_CNT_EN).

## Operation
- Reset values: bclk=0, lrclk=1, sdata=0, sample_ready=1, underrun=0, underrun_count=0; holding and shift registers cleared.
- Divider counts 0..CLK_DIV-1; on terminal count bclk toggles. A 1→0 toggle is a "fall event".
- Bit counter 0..2*SLOT_BITS-1 advances on each fall event; wraps to 0 = frame boundary.
- lrclk updates on fall events: 0 for bit counter 0..SLOT_BITS-1, 1 otherwise.
- Frame word = {left, (SLOT_BITS-DATA_WIDTH) zeros, right, zeros}, sent MSB-first; sdata is that stream delayed by one bclk (standard I2S one-bit delay), so left MSB appears on the fall event after lrclk goes 0.
- Handshake: holding register loads on valid & ready; sample_ready drops next clk and rises when the frame boundary moves the pair into the shift register. valid while not ready is ignored (no loss, producer holds).
- Frame boundary with holding full: transfer, holding becomes empty. With holding empty: shift register loaded with zeros (mute), underrun pulses for one clk.
- Simultaneous handshake and frame boundary on the same clk: transfer takes the old holding content (if any), new pair lands in holding; if holding was empty, the new pair is transmitted in this frame and no underrun is raised.
- State machine: IDLE (after reset, bclk running, zeros sent, underrun suppressed until first pair accepted) → RUN (underrun checks active). RUN returns to IDLE only on reset.
- Reset mid-frame: all outputs return to reset values immediately; partial frame discarded.

## Timing
- bclk period 2*CLK_DIV clk; frame 4*SLOT_BITS*CLK_DIV clk.
- First fall event at clk 2*CLK_DIV after reset release.
- Sample acceptance to its left MSB on sdata: at most one frame plus one bclk.
- underrun and sample_ready change on the clk of the frame-boundary fall event.

## Configuration
- I2S_TX_UNDERRUN_CNT_EN defined: underrun_count port present, increments on each underrun pulse, saturates at 16'hFFFF, cleared only by reset.
- Undefined: port and counter absent; underrun pulse still generated.

## Structure
- Shared audio package: sample width constant, I2S slot/left/right encoding constants, tx state enum (IDLE, RUN).
- One sub-module: i2s_clk_gen (divider, bclk, fall-event strobe, bit counter, lrclk).

## Test plan
- DATA_WIDTH=16, SLOT_BITS=16, CLK_DIV=2: reset, then bclk period 4 clk, lrclk period 128 clk, sdata=0 throughout, underrun never pulses in IDLE.
- Send L=16'hA5C3, R=16'h1234 -> decoded frame shows left 16'hA5C3, right 16'h1234, MSB one bclk after lrclk edge.
- SLOT_BITS=24: L=16'h8001 -> 16 data bits then 8 zero bits per slot.
- Hold sample_valid with a second pair while ready=0 -> second pair sent exactly in the following frame, none dropped.
- After RUN, withhold samples for 3 frames -> 3 underrun pulses, zero frames, underrun_count=3 with macro defined.
- Assert reset_n low mid-right-slot -> bclk=0, lrclk=1, sdata=0, sample_ready=1 on same clk.
